// File: rtl/lane_word_align_pkg.sv
// Shared types and constants for the lane word aligner: FSM states,
// training-pattern generators and the offset-width helper.
package lane_word_align_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_CONFIRM   = 2'd1,
        ST_SLIP_WAIT = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    // Widest lane the pattern helpers can describe; callers keep the low w bits.
    localparam int PAT_MAX = 1024;

    function automatic logic [PAT_MAX-1:0] low_mask(input int w);
        return ~({PAT_MAX{1'b1}} << w);
    endfunction

    function automatic logic [PAT_MAX-1:0] pat0(input int w);
        return {(PAT_MAX/4){4'h5}} & low_mask(w);
    endfunction

    function automatic logic [PAT_MAX-1:0] pat1(input int w);
        return {(PAT_MAX/4){4'hA}} & low_mask(w);
    endfunction

    function automatic int off_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_word_align_window.sv
// Combinational rotation window: builds every candidate word from the
// history, flags training-pattern matches and picks the lowest match.
module lane_word_align_window
    import lane_word_align_pkg::*;
#(
    parameter int W    = 128,
    parameter int STEP = 8,
    localparam int N   = W / STEP,
    localparam int OW  = off_width(W / STEP)
) (
    input  logic [0:W-1]  idata,
    input  logic [0:W-1]  b1,
    input  logic [0:W-1]  b2,
    input  logic [OW-1:0] sel,
    output logic [N-1:0]  match,
    output logic          any_match,
    output logic [OW-1:0] winner,
    output logic [0:W-1]  cur_sel
);

    localparam logic [PAT_MAX-1:0] P0_FULL = pat0(W);
    localparam logic [PAT_MAX-1:0] P1_FULL = pat1(W);
    localparam logic [0:W-1]       P0      = P0_FULL[W-1:0];
    localparam logic [0:W-1]       P1      = P1_FULL[W-1:0];

    logic [0:2*W-1] cur_cat;
    logic [0:2*W-1] prv_cat;
    logic [0:W-1]   cur_k [N];
    logic [0:W-1]   prv_k [N];

    assign cur_cat = {b1, idata};
    assign prv_cat = {b2, b1};

    // Candidate k is the stream viewed k*STEP bits earlier than idata.
    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cur_k[k] = cur_cat[W-k*STEP +: W];
        assign prv_k[k] = prv_cat[W-k*STEP +: W];
        assign match[k] = ((cur_k[k] == P0) || (cur_k[k] == P1)) && (prv_k[k] == ~cur_k[k]);
    end

    always_comb begin
        any_match = 1'b0;
        winner    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (match[k]) begin
                any_match = 1'b1;
                winner    = OW'(k);
            end
        end
    end

    assign cur_sel = cur_k[sel];

endmodule

// File: rtl/lane_word_align.sv
// Receive-side lane word aligner: search, confirm, bitslip and lock FSM
// around the rotation window, with bounded-retry failure reporting.
module lane_word_align
    import lane_word_align_pkg::*;
#(
    parameter int W             = 128,
    parameter int STEP          = 8,
    parameter int SEARCH_CYCLES = 4,
    parameter int SLIP_WAIT     = 32,
    parameter int LOCK_COUNT    = 4,
    parameter int MAX_SLIPS     = W,
    localparam int N            = W / STEP,
    localparam int OW           = off_width(W / STEP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [0:W-1]  idata,
    input  logic          relock,
    output logic [0:W-1]  odata,
    output logic          aligned,
    output logic          oslip,
    output logic [OW-1:0] offset,
    output logic          fail,
    output state_t        dbg_state
);

    localparam int NMW = $clog2(SEARCH_CYCLES + 1);
    localparam int WTW = $clog2(SLIP_WAIT + 1);
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam int SLW = $clog2(MAX_SLIPS + 1);

    state_t         state, state_n;
    logic [0:W-1]   b1, b2;
    logic [NMW-1:0] nomatch, nomatch_n;
    logic [WTW-1:0] wait_cnt, wait_n;
    logic [LCW-1:0] cnt, cnt_n;
    logic [SLW-1:0] slips, slips_n;
    logic [OW-1:0]  offset_n;
    logic [0:W-1]   odata_n;
    logic           aligned_n;
    logic           oslip_n;

    logic [N-1:0]   match;
    logic           any_match;
    logic [OW-1:0]  winner;
    logic [OW-1:0]  mux_sel;
    logic [0:W-1]   cur_sel;
    logic           match_sel;

    // In SEARCH the mux follows the live winner so a one-match lock loads the right word.
    assign mux_sel   = (state == ST_SEARCH) ? winner : offset;
    assign match_sel = match[offset];

    lane_word_align_window #(
        .W    (W),
        .STEP (STEP)
    ) u_window (
        .idata     (idata),
        .b1        (b1),
        .b2        (b2),
        .sel       (mux_sel),
        .match     (match),
        .any_match (any_match),
        .winner    (winner),
        .cur_sel   (cur_sel)
    );

    always_comb begin
        state_n   = state;
        nomatch_n = nomatch;
        wait_n    = wait_cnt;
        cnt_n     = cnt;
        slips_n   = slips;
        offset_n  = offset;
        odata_n   = odata;
        aligned_n = aligned;
        oslip_n   = 1'b0;
        if (relock) begin
            state_n   = ST_SEARCH;
            nomatch_n = '0;
            wait_n    = '0;
            cnt_n     = '0;
            aligned_n = 1'b0;
            odata_n   = '0;
            if (state == ST_LOCKED) slips_n = '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (any_match) begin
                        offset_n  = winner;
                        cnt_n     = LCW'(1);
                        nomatch_n = '0;
                        if (LOCK_COUNT == 1) begin
                            state_n   = ST_LOCKED;
                            aligned_n = 1'b1;
                            odata_n   = cur_sel;
                            slips_n   = '0;
                        end else begin
                            state_n = ST_CONFIRM;
                        end
                    end else if (nomatch == NMW'(SEARCH_CYCLES - 1)) begin
                        oslip_n   = 1'b1;
                        nomatch_n = '0;
                        wait_n    = '0;
                        state_n   = ST_SLIP_WAIT;
                        if (slips != SLW'(MAX_SLIPS)) slips_n = slips + 1'b1;
                    end else begin
                        nomatch_n = nomatch + 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (!match_sel) begin
                        state_n   = ST_SEARCH;
                        nomatch_n = '0;
                        cnt_n     = '0;
                    end else if (cnt == LCW'(LOCK_COUNT - 1)) begin
                        state_n   = ST_LOCKED;
                        aligned_n = 1'b1;
                        odata_n   = cur_sel;
                        slips_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt == WTW'(SLIP_WAIT - 1)) begin
                        state_n = ST_SEARCH;
                        wait_n  = '0;
                    end else begin
                        wait_n = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    odata_n   = cur_sel;
                    aligned_n = 1'b1;
                    slips_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_SEARCH;
            b1       <= '0;
            b2       <= '0;
            nomatch  <= '0;
            wait_cnt <= '0;
            cnt      <= '0;
            slips    <= '0;
            offset   <= '0;
            odata    <= '0;
            aligned  <= 1'b0;
            oslip    <= 1'b0;
        end else begin
            state    <= state_n;
            b1       <= idata;
            b2       <= b1;
            nomatch  <= nomatch_n;
            wait_cnt <= wait_n;
            cnt      <= cnt_n;
            slips    <= slips_n;
            offset   <= offset_n;
            odata    <= odata_n;
            aligned  <= aligned_n;
            oslip    <= oslip_n;
        end
    end

    assign fail      = (slips >= SLW'(MAX_SLIPS));
    assign dbg_state = state;

endmodule
